// File: rtl/mips_pkg.sv
// Shared definitions for the MEM stage of the 5-stage MIPS pipeline.
package mips_pkg;

  // MEM-stage controller states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Default number of BUSY cycles allowed before an access is aborted.
  localparam int TIMEOUT_DEFAULT = 16;

  // MEM/WB pipeline register contents.
  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] mdata;
    logic        m2reg;
    logic        wreg;
    logic [4:0]  wn;
  } memwb_t;

  // A data-memory access must target a whole 32-bit word.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/link45.sv
// MEM/WB pipeline register. A bubble kills the write-back controls and
// keeps the data fields as they were; a load copies the EX/MEM fields and,
// for completed loads, the memory read data.
module Link45
  import mips_pkg::*;
(
  input  logic   Clock,
  input  logic   Reset,
  input  logic   i_load,
  input  logic   i_bubble,
  input  logic   i_mdata_we,
  input  memwb_t i_d,
  output memwb_t o_q
);

  memwb_t r_q;

  // Pipeline register update; bubble has priority over load.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_q <= '0;
    end else if (i_bubble) begin
      r_q.m2reg <= 1'b0;
      r_q.wreg  <= 1'b0;
    end else if (i_load) begin
      r_q.alu   <= i_d.alu;
      r_q.m2reg <= i_d.m2reg;
      r_q.wreg  <= i_d.wreg;
      r_q.wn    <= i_d.wn;
      if (i_mdata_we) begin
        r_q.mdata <= i_d.mdata;
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: issues load/store requests on the data-memory bus,
// stalls the upstream pipeline while a request is outstanding, flags
// misaligned or timed-out accesses, and drives the MEM/WB register.
//
// Bus handshake: the unit raises mreq together with mwe/maddr/mwdata and
// holds all four stable until the clock edge after the memory pulses mack
// for one cycle (or until the unit gives up after TIMEOUT BUSY cycles).
// mack is only meaningful while a request is outstanding; mreq always
// returns low for at least one cycle before the next request.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Alu_Result_mem,
  input  logic [31:0] rb_mem,
  input  logic        m2reg_mem,
  input  logic        wmem_mem,
  input  logic [4:0]  wn_mem,
  input  logic        wreg_mem,
  output logic        mreq,
  output logic        mwe,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  input  logic [31:0] mrdata,
  input  logic        mack,
  output logic        stall_mem,
  output logic        mem_err,
  output logic [31:0] Alu_Result_wb,
  output logic [31:0] mdata_wb,
  output logic        m2reg_wb,
  output logic        wreg_wb,
  output logic [4:0]  wn_wb,
  output mem_state_t  o_dbg_state
);

  localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mreq;
  logic             r_mwe;
  logic [31:0]      r_maddr;
  logic [31:0]      r_mwdata;
  logic             r_mem_err;

  logic       w_access;
  logic       w_aligned;
  logic       w_is_store;
  logic       w_timeout;
  mem_state_t w_next_state;
  logic       w_start;
  logic       w_misalign;
  logic       w_done;
  logic       w_abort;
  logic       w_wait;
  logic       w_stall;
  logic       w_wb_load;
  logic       w_wb_bubble;
  logic       w_wb_mdata_we;
  memwb_t     w_wb_d;
  memwb_t     w_wb_q;

  // A load that also has the store bit set is still treated as a load.
  assign w_access   = m2reg_mem | wmem_mem;
  assign w_aligned  = is_word_aligned(Alu_Result_mem);
  assign w_is_store = wmem_mem & ~m2reg_mem;
  assign w_timeout  = (r_cnt == CNT_LAST);

  // Next-state and per-cycle action decode.
  always_comb begin
    w_next_state  = r_state;
    w_start       = 1'b0;
    w_misalign    = 1'b0;
    w_done        = 1'b0;
    w_abort       = 1'b0;
    w_wait        = 1'b0;
    w_stall       = 1'b0;
    w_wb_load     = 1'b0;
    w_wb_bubble   = 1'b0;
    w_wb_mdata_we = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          w_wb_bubble = 1'b1;
          if (w_aligned) begin
            w_start      = 1'b1;
            w_stall      = 1'b1;
            w_next_state = BUSY;
          end else begin
            w_misalign = 1'b1;
          end
        end else begin
          w_wb_load = 1'b1;
        end
      end
      BUSY: begin
        if (mack) begin
          w_done        = 1'b1;
          w_wb_load     = 1'b1;
          w_wb_mdata_we = m2reg_mem;
          w_next_state  = IDLE;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_wb_bubble  = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_wait      = 1'b1;
          w_stall     = 1'b1;
          w_wb_bubble = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State and BUSY-cycle counter.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_cnt <= '0;
      end else if (w_wait) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Bus registers: captured when the request starts, held until it ends.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_mreq   <= 1'b0;
      r_mwe    <= 1'b0;
      r_maddr  <= '0;
      r_mwdata <= '0;
    end else if (w_start) begin
      r_mreq   <= 1'b1;
      r_mwe    <= w_is_store;
      r_maddr  <= {Alu_Result_mem[31:2], 2'b00};
      r_mwdata <= rb_mem;
    end else if (w_done || w_abort) begin
      r_mreq <= 1'b0;
    end
  end

  // Sticky error flag for misaligned or timed-out accesses.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_mem_err <= 1'b0;
    end else if (w_misalign || w_abort) begin
      r_mem_err <= 1'b1;
    end
  end

  assign w_wb_d.alu   = Alu_Result_mem;
  assign w_wb_d.mdata = mrdata;
  assign w_wb_d.m2reg = m2reg_mem;
  assign w_wb_d.wreg  = wreg_mem;
  assign w_wb_d.wn    = wn_mem;

  Link45 u_link45 (
    .Clock      (Clock),
    .Reset      (Reset),
    .i_load     (w_wb_load),
    .i_bubble   (w_wb_bubble),
    .i_mdata_we (w_wb_mdata_we),
    .i_d        (w_wb_d),
    .o_q        (w_wb_q)
  );

  // Stall is released while reset is held so the pipeline is never frozen by
  // an instruction that the reset is about to discard.
  assign stall_mem     = w_stall & ~Reset;
  assign mreq          = r_mreq;
  assign mwe           = r_mwe;
  assign maddr         = r_maddr;
  assign mwdata        = r_mwdata;
  assign mem_err       = r_mem_err;
  assign Alu_Result_wb = w_wb_q.alu;
  assign mdata_wb      = w_wb_q.mdata;
  assign m2reg_wb      = w_wb_q.m2reg;
  assign wreg_wb       = w_wb_q.wreg;
  assign wn_wb         = w_wb_q.wn;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: an instruction-level model produces the
// expected per-cycle outputs of each instruction; one compare process checks
// them on the falling edge. Directed cases pin the model with literals.
module tb_mem_access_unit;
  import mips_pkg::*;

  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  logic [31:0] Alu_Result_mem, rb_mem, mrdata;
  logic        m2reg_mem, wmem_mem, wreg_mem, mack;
  logic [4:0]  wn_mem;
  logic        mreq, mwe, stall_mem, mem_err, m2reg_wb, wreg_wb;
  logic [31:0] maddr, mwdata, Alu_Result_wb, mdata_wb;
  logic [4:0]  wn_wb;
  mem_state_t  dbg_state;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset),
    .Alu_Result_mem(Alu_Result_mem), .rb_mem(rb_mem),
    .m2reg_mem(m2reg_mem), .wmem_mem(wmem_mem), .wn_mem(wn_mem), .wreg_mem(wreg_mem),
    .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata),
    .mrdata(mrdata), .mack(mack), .stall_mem(stall_mem), .mem_err(mem_err),
    .Alu_Result_wb(Alu_Result_wb), .mdata_wb(mdata_wb),
    .m2reg_wb(m2reg_wb), .wreg_wb(wreg_wb), .wn_wb(wn_wb),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        stall;
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        err;
    logic [31:0] alu;
    logic [31:0] mdata;
    logic        m2reg;
    logic        wreg;
    logic [4:0]  wn;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int mreq_cnt = 0;

  // Model of the architecturally visible registers.
  logic        m_mreq, m_mwe, m_err, m_m2reg, m_wreg;
  logic [31:0] m_maddr, m_mwdata, m_alu, m_mdata;
  logic [4:0]  m_wn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mreq = 0; m_mwe = 0; m_maddr = 0; m_mwdata = 0; m_err = 0;
    m_alu = 0; m_mdata = 0; m_m2reg = 0; m_wreg = 0; m_wn = 0;
  endtask

  // A dropped or waiting instruction writes nothing back.
  task automatic bubble();
    m_m2reg = 0;
    m_wreg  = 0;
  endtask

  task automatic push(input logic stall);
    exp_t e;
    e.stall = stall;  e.mreq = m_mreq; e.mwe = m_mwe; e.maddr = m_maddr;
    e.mwdata = m_mwdata; e.err = m_err; e.alu = m_alu; e.mdata = m_mdata;
    e.m2reg = m_m2reg; e.wreg = m_wreg; e.wn = m_wn;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  // Compare process: one expected entry per driven cycle.
  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall_mem", {31'b0, stall_mem}, {31'b0, e.stall});
      check("mreq", {31'b0, mreq}, {31'b0, e.mreq});
      check("mwe", {31'b0, mwe}, {31'b0, e.mwe});
      check("maddr", maddr, e.maddr);
      check("mwdata", mwdata, e.mwdata);
      check("mem_err", {31'b0, mem_err}, {31'b0, e.err});
      check("Alu_Result_wb", Alu_Result_wb, e.alu);
      check("mdata_wb", mdata_wb, e.mdata);
      check("m2reg_wb", {31'b0, m2reg_wb}, {31'b0, e.m2reg});
      check("wreg_wb", {31'b0, wreg_wb}, {31'b0, e.wreg});
      check("wn_wb", {27'b0, wn_wb}, {27'b0, e.wn});
      if (stall_mem) stall_cnt++;
      if (mreq) mreq_cnt++;
    end
  end

  // ---------------- driver ----------------
  // Presents one instruction in EX/MEM (held while stalled) and plays the
  // memory: mack arrives after wait_n BUSY cycles (never if wait_n >= TO).
  // While no request is outstanding mack is toggled randomly to show it is
  // ignored.
  task automatic run_instr(input logic ld, input logic st, input logic [31:0] addr,
                           input logic [31:0] data, input logic [4:0] wn,
                           input logic wreg, input int wait_n, input logic [31:0] rdata);
    Alu_Result_mem = addr; rb_mem = data; m2reg_mem = ld; wmem_mem = st;
    wn_mem = wn; wreg_mem = wreg;
    mack = 1'($urandom_range(0, 1));
    mrdata = $urandom;
    if (!(ld || st)) begin
      push(0);
      next_cycle();
      m_alu = addr; m_m2reg = 0; m_wreg = wreg; m_wn = wn;
    end else if (addr[1:0] != 2'b00) begin
      push(0);
      next_cycle();
      m_err = 1;
      bubble();
    end else begin
      push(1);
      next_cycle();
      bubble();
      m_mreq = 1; m_mwe = st & ~ld; m_maddr = addr; m_mwdata = data;
      for (int j = 0; j < TO; j++) begin
        if (j == wait_n) begin
          mack = 1; mrdata = rdata;
          push(0);
          next_cycle();
          m_mreq = 0; m_alu = addr; m_m2reg = ld; m_wreg = wreg; m_wn = wn;
          if (ld) m_mdata = rdata;
          break;
        end else if (j == TO - 1) begin
          mack = 0;
          push(0);
          next_cycle();
          m_mreq = 0; m_err = 1;
          bubble();
        end else begin
          mack = 0;
          push(1);
          next_cycle();
          bubble();
        end
      end
    end
    mack = 0;
  endtask

  task automatic random_batch(input int n, input bit allow_err);
    for (int i = 0; i < n; i++) begin
      int kind;
      int w;
      logic ld, st;
      logic [31:0] a;
      kind = $urandom_range(0, allow_err ? 9 : 8);
      a = $urandom & 32'h0000_FFFC;
      ld = 0; st = 0;
      case (kind)
        0, 1, 2, 3: a = $urandom;
        4, 5:       ld = 1;
        6, 7:       st = 1;
        8:          begin ld = 1; st = 1; end
        default: begin
          if ($urandom_range(0, 1) == 1) ld = 1; else st = 1;
          a[1:0] = 2'($urandom_range(1, 3));
        end
      endcase
      w = $urandom_range(0, allow_err ? TO : TO - 1);
      run_instr(ld, st, a, $urandom, 5'($urandom), 1'($urandom_range(0, 1)), w, $urandom);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    Reset = 1; Alu_Result_mem = 0; rb_mem = 0; m2reg_mem = 0; wmem_mem = 0;
    wn_mem = 0; wreg_mem = 0; mack = 0; mrdata = 0;
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    check("reset_mreq", {31'b0, mreq}, 32'd0);
    check("reset_stall", {31'b0, stall_mem}, 32'd0);
    check("reset_err", {31'b0, mem_err}, 32'd0);
    check("reset_alu_wb", Alu_Result_wb, 32'd0);
    check("reset_wreg_wb", {31'b0, wreg_wb}, 32'd0);
    check("reset_state", {31'b0, dbg_state}, {31'b0, IDLE});
    Reset = 0;

    // ALU op passes through in one cycle.
    stall_cnt = 0;
    run_instr(0, 0, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 32'h0);
    check("alu_result", Alu_Result_wb, 32'h1234);
    check("alu_wn", {27'b0, wn_wb}, 32'd5);
    check("alu_wreg", {31'b0, wreg_wb}, 32'd1);
    check("alu_stall_cycles", stall_cnt, 32'd0);

    // Load from 0x40, ack after three waiting BUSY cycles.
    stall_cnt = 0; mreq_cnt = 0;
    run_instr(1, 0, 32'h40, 32'h0, 5'd7, 1'b1, 3, 32'hDEAD_BEEF);
    check("load_stall_cycles", stall_cnt, 32'd4);
    check("load_mreq_cycles", mreq_cnt, 32'd4);
    check("load_mdata", mdata_wb, 32'hDEAD_BEEF);
    check("load_m2reg", {31'b0, m2reg_wb}, 32'd1);

    // Store with zero-wait ack.
    stall_cnt = 0; mreq_cnt = 0;
    run_instr(0, 1, 32'h80, 32'hCAFE_F00D, 5'd0, 1'b0, 0, 32'h0);
    check("store_stall_cycles", stall_cnt, 32'd1);
    check("store_mreq_cycles", mreq_cnt, 32'd1);
    check("store_mwe", {31'b0, mwe}, 32'd1);
    check("store_mwdata", mwdata, 32'hCAFE_F00D);
    check("store_maddr", maddr, 32'h80);

    // Random traffic with no errors, so mem_err must stay low.
    random_batch(60, 1'b0);
    check("no_err_yet", {31'b0, mem_err}, 32'd0);

    // Misaligned load is dropped.
    stall_cnt = 0; mreq_cnt = 0;
    run_instr(1, 0, 32'h42, 32'h0, 5'd3, 1'b1, 0, 32'h0);
    check("misalign_err", {31'b0, mem_err}, 32'd1);
    check("misalign_wreg", {31'b0, wreg_wb}, 32'd0);
    check("misalign_stall", stall_cnt, 32'd0);
    check("misalign_mreq", mreq_cnt, 32'd0);

    // Load never acknowledged: timeout.
    stall_cnt = 0; mreq_cnt = 0;
    run_instr(1, 0, 32'h100, 32'h0, 5'd4, 1'b1, 99, 32'h0);
    check("timeout_mreq_cycles", mreq_cnt, 32'd4);
    check("timeout_stall_cycles", stall_cnt, 32'd4);
    check("timeout_err", {31'b0, mem_err}, 32'd1);
    check("timeout_wreg", {31'b0, wreg_wb}, 32'd0);
    check("timeout_state", {31'b0, dbg_state}, {31'b0, IDLE});

    // Full random mix including errors and timeouts.
    random_batch(150, 1'b1);

    // Reset in the middle of a BUSY access.
    Alu_Result_mem = 32'h200; m2reg_mem = 1; wmem_mem = 0; wreg_mem = 1;
    wn_mem = 5'd3; mack = 0;
    next_cycle();
    check("pre_reset_mreq", {31'b0, mreq}, 32'd1);
    check("pre_reset_stall", {31'b0, stall_mem}, 32'd1);
    check("pre_reset_err", {31'b0, mem_err}, 32'd1);
    #2;
    Reset = 1;
    #1;
    check("async_reset_mreq", {31'b0, mreq}, 32'd0);
    check("async_reset_stall", {31'b0, stall_mem}, 32'd0);
    check("async_reset_err", {31'b0, mem_err}, 32'd0);
    check("async_reset_state", {31'b0, dbg_state}, {31'b0, IDLE});
    Alu_Result_mem = 0; rb_mem = 0; m2reg_mem = 0; wmem_mem = 0;
    wreg_mem = 0; wn_mem = 0;
    @(negedge Clock);
    Reset = 0;
    model_reset();
    next_cycle();
    run_instr(0, 0, 32'hABCD, 32'h0, 5'd9, 1'b1, 0, 32'h0);
    check("post_reset_alu", Alu_Result_wb, 32'hABCD);
    check("post_reset_wn", {27'b0, wn_wb}, 32'd9);
    check("post_reset_wreg", {31'b0, wreg_wb}, 32'd1);
    random_batch(20, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
